// File: rtl/morse_decoder.sv
// Morse receive decoder: samples a keying line, measures mark/space runs in
// eighths of a Morse unit and maps the dot/dash pattern to the 3-bit A..H code.
module morse_decoder #(
    parameter int SAMPLE_DIV = 3125000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       din,
    output logic [2:0] letter,
    output logic       letter_valid,
    output logic       letter_error,
    output logic       busy
);

    localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] MARK  = 3'd1;
    localparam logic [2:0] SPACE = 3'd2;
    localparam logic [2:0] EMIT  = 3'd3;
    localparam logic [2:0] JAM   = 3'd4;

    logic          din_meta, din_sync;
    logic [DW-1:0] div_cnt;
    logic          tick;
    logic [2:0]    state;
    logic [5:0]    mark_len, space_len;
    logic [5:0]    mark_inc, space_inc;
    logic [3:0]    pattern;
    logic [2:0]    count;
    logic          error_pending;
    logic [2:0]    code;
    logic          code_hit;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            din_meta <= 1'b0;
            din_sync <= 1'b0;
            div_cnt  <= '0;
        end else begin
            din_meta <= din;
            din_sync <= din_meta;
            div_cnt  <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
        end
    end

    assign tick      = (div_cnt == DIV_LAST);
    assign mark_inc  = (mark_len == 6'd63) ? 6'd63 : mark_len + 6'd1;
    assign space_inc = (space_len == 6'd63) ? 6'd63 : space_len + 6'd1;
    assign busy      = (state != IDLE);

    // Pattern is right-aligned with the first element in bit count-1, so
    // {count, pattern} is already the left-justified key.
    always_comb begin
        code     = 3'd0;
        code_hit = 1'b1;
        case ({count, pattern})
            {3'd2, 4'b0001}: code = 3'd0;
            {3'd4, 4'b1000}: code = 3'd1;
            {3'd4, 4'b1010}: code = 3'd2;
            {3'd3, 4'b0100}: code = 3'd3;
            {3'd1, 4'b0000}: code = 3'd4;
            {3'd4, 4'b0010}: code = 3'd5;
            {3'd3, 4'b0110}: code = 3'd6;
            {3'd4, 4'b0000}: code = 3'd7;
            default:         code_hit = 1'b0;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            mark_len      <= '0;
            space_len     <= '0;
            pattern       <= '0;
            count         <= '0;
            error_pending <= 1'b0;
            letter        <= '0;
            letter_valid  <= 1'b0;
            letter_error  <= 1'b0;
        end else begin
            letter_valid <= 1'b0;
            letter_error <= 1'b0;
            case (state)
                IDLE: begin
                    pattern       <= '0;
                    count         <= '0;
                    mark_len      <= '0;
                    space_len     <= '0;
                    error_pending <= 1'b0;
                    if (tick && din_sync) begin
                        state    <= MARK;
                        mark_len <= 6'd1;
                    end
                end
                MARK: if (tick) begin
                    if (din_sync) begin
                        mark_len <= mark_inc;
                        if (mark_inc == 6'd40) begin
                            letter_error <= 1'b1;
                            state        <= JAM;
                        end
                    end else if (mark_len < 6'd4) begin
                        state <= (count == 3'd0) ? IDLE : SPACE;
                    end else begin
                        space_len <= 6'd1;
                        state     <= SPACE;
                        if (count == 3'd4) begin
                            letter_error  <= 1'b1;
                            error_pending <= 1'b1;
                        end else begin
                            pattern <= {pattern[2:0], (mark_len >= 6'd16)};
                            count   <= count + 3'd1;
                        end
                    end
                end
                SPACE: if (tick) begin
                    if (din_sync) begin
                        state    <= MARK;
                        mark_len <= 6'd1;
                    end else begin
                        space_len <= space_inc;
                        // Result is registered here so the pulses are visible
                        // during the single EMIT cycle that follows the tick.
                        if (space_inc == 6'd16) begin
                            state <= EMIT;
                            if (!error_pending) begin
                                if (code_hit) begin
                                    letter       <= code;
                                    letter_valid <= 1'b1;
                                end else begin
                                    letter_error <= 1'b1;
                                end
                            end
                        end
                    end
                end
                EMIT: state <= IDLE;
                JAM:  if (tick && !din_sync) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_morse_decoder.sv
// Randomized scoreboard bench for morse_decoder: a run-length reference model
// queues expected letter/error events, a monitor pops them on every DUT pulse.
module tb_morse_decoder;

    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       din;
    logic [2:0] letter;
    logic       letter_valid;
    logic       letter_error;
    logic       busy;

    always #5 clk = ~clk;

    morse_decoder #(.SAMPLE_DIV(SD)) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .din         (din),
        .letter      (letter),
        .letter_valid(letter_valid),
        .letter_error(letter_error),
        .busy        (busy)
    );

    typedef struct {
        bit         is_err;
        logic [2:0] letter;
    } exp_t;

    exp_t  exp_q[$];
    exp_t  mon_e;
    int    checks   = 0;
    int    failures = 0;

    string tbl[8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};

    // reference model state, in terms of runs of samples
    string      elems;
    bit         in_letter, err_pending, skip_next;
    int         space_acc;
    logic [2:0] held;

    function automatic void check(string name, bit ok, int act, int expv);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endfunction

    function automatic void push(bit e, logic [2:0] l);
        exp_t x;
        x.is_err = e;
        x.letter = l;
        exp_q.push_back(x);
    endfunction

    function automatic void clear_letter();
        elems       = "";
        in_letter   = 0;
        err_pending = 0;
        skip_next   = 0;
        space_acc   = 0;
    endfunction

    function automatic void model_reset();
        clear_letter();
        held = 3'd0;
    endfunction

    function automatic void model_mark(int len);
        if (len >= 40) begin
            push(1'b1, held);
            clear_letter();
        end else if (len < 4) begin
            if (in_letter) skip_next = 1;
        end else begin
            if (elems.len() == 4) begin
                push(1'b1, held);
                err_pending = 1;
            end else if (len >= 16) begin
                elems = {elems, "-"};
            end else begin
                elems = {elems, "."};
            end
            in_letter = 1;
            space_acc = 0;
            skip_next = 0;
        end
    endfunction

    function automatic void model_space(int len);
        int found;
        if (!in_letter) return;
        space_acc += len - (skip_next ? 1 : 0);
        skip_next = 0;
        if (space_acc >= 16) begin
            if (!err_pending) begin
                found = -1;
                for (int i = 0; i < 8; i++) if (tbl[i] == elems) found = i;
                if (found >= 0) begin
                    held = 3'(found);
                    push(1'b0, held);
                end else begin
                    push(1'b1, held);
                end
            end
            clear_letter();
        end
    endfunction

    task automatic run(bit lvl, int n);
        if (lvl) model_mark(n);
        else     model_space(n);
        din = lvl;
        repeat (n * SD) @(negedge clk);
    endtask

    task automatic send(string p, int dot, int dash, int gap, int lgap);
        for (int i = 0; i < p.len(); i++) begin
            run(1'b1, (p[i] == 8'h2D) ? dash : dot);
            if (i != p.len() - 1) run(1'b0, gap);
        end
        run(1'b0, lgap);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!reset && (letter_valid || letter_error)) begin
            if (letter_valid && letter_error) begin
                check("both_pulses", 1'b0, 1, 0);
            end else if (exp_q.size() == 0) begin
                check("unexpected_pulse", 1'b0, {letter_error, letter}, -1);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_kind", letter_error == mon_e.is_err, int'(letter_error), int'(mon_e.is_err));
                check("letter", letter === mon_e.letter, int'(letter), int'(mon_e.letter));
            end
        end
    end

    initial begin
        string p;
        int    n, k;
        model_reset();
        din   = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_letter", letter === 3'd0, int'(letter), 0);
        check("rst_valid", letter_valid === 1'b0, int'(letter_valid), 0);
        check("rst_error", letter_error === 1'b0, int'(letter_error), 0);
        check("rst_busy", busy === 1'b0, int'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        run(1'b0, 4);

        // encoder-timed loopback, one letter per code
        for (int c = 0; c < 8; c++) send(tbl[c], 8, 24, 8, 24);

        // glitch inside a gap of A, then isolated glitch from idle
        run(1'b1, 8); run(1'b0, 3); run(1'b1, 2); run(1'b0, 3); run(1'b1, 24); run(1'b0, 20);
        run(1'b1, 2); run(1'b0, 3);
        check("glitch_idle_busy", busy === 1'b0, int'(busy), 0);
        run(1'b0, 10);

        // invalid letter O, then five-dot overflow
        send("---", 8, 24, 8, 24);
        send(".....", 8, 24, 8, 24);

        // stuck key
        run(1'b1, 45);
        check("jam_busy", busy === 1'b1, int'(busy), 1);
        run(1'b0, 3);
        check("jam_release_busy", busy === 1'b0, int'(busy), 0);
        run(1'b0, 5);

        // reset in the middle of a dash
        check("pre_reset_drain", exp_q.size() == 0, exp_q.size(), 0);
        din = 1'b1;
        repeat (12 * SD) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_letter", letter === 3'd0, int'(letter), 0);
        check("midrst_valid", letter_valid === 1'b0, int'(letter_valid), 0);
        check("midrst_error", letter_error === 1'b0, int'(letter_error), 0);
        check("midrst_busy", busy === 1'b0, int'(busy), 0);
        din = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        run(1'b0, 3);
        send(".", 8, 24, 8, 24);

        // randomized letters with glitches, odd patterns and stuck keys
        for (int l = 0; l < 60; l++) begin
            k = $urandom_range(0, 19);
            if (k == 0) begin
                run(1'b1, $urandom_range(40, 50));
                run(1'b0, $urandom_range(5, 20));
            end else begin
                if (k < 16) begin
                    p = tbl[$urandom_range(0, 7)];
                end else begin
                    p = "";
                    n = $urandom_range(1, 5);
                    for (int i = 0; i < n; i++) p = ($urandom_range(0, 1) != 0) ? {p, "-"} : {p, "."};
                end
                for (int i = 0; i < p.len(); i++) begin
                    if (p[i] == 8'h2D) run(1'b1, $urandom_range(16, 39));
                    else               run(1'b1, $urandom_range(4, 15));
                    if (i != p.len() - 1) begin
                        if ($urandom_range(0, 5) == 0) begin
                            run(1'b0, $urandom_range(1, 7));
                            run(1'b1, $urandom_range(1, 3));
                            run(1'b0, $urandom_range(1, 7));
                        end else begin
                            run(1'b0, $urandom_range(1, 15));
                        end
                    end
                end
                run(1'b0, $urandom_range(16, 30));
            end
        end

        run(1'b0, 30);
        check("final_drain", exp_q.size() == 0, exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
